// File: rtl/psu_pkg.sv
// psu_pkg: shared definitions for the param_shift_unit slice.
//   - mode encodings PSU_SHL / PSU_SHR / PSU_ROL / PSU_ROR
//     (PSU_ROR becomes arithmetic right shift when PSU_ASR_EN is defined)
//   - FSM state encoding psu_state_e (IDLE / SHIFT / DONE)
//   - psu_clog2 helper used to size the shift counter
package psu_pkg;

  localparam logic [1:0] PSU_SHL = 2'b00;
  localparam logic [1:0] PSU_SHR = 2'b01;
  localparam logic [1:0] PSU_ROL = 2'b10;
  localparam logic [1:0] PSU_ROR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } psu_state_e;

  // Ceiling log2; psu_clog2(WIDTH+1) bits can hold every count 0..WIDTH.
  function automatic int psu_clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res++;
    return res;
  endfunction

endpackage

// File: rtl/psu_step.sv
// psu_step: combinational single-bit shift/rotate step.
// Config macro: PSU_ASR_EN (defined -> mode 11 is arithmetic right shift,
//               undefined -> mode 11 is rotate right).
// Ports:
//   so_cur   in  WIDTH  current register word
//   mode     in  2      step mode (PSU_SHL/SHR/ROL/ROR)
//   ser_in   in  1      fill bit for SHL (bit 0) and SHR (bit WIDTH-1)
//   so_next  out WIDTH  word after one step
//   out_bit  out 1      bit leaving the word (wrapped bit for rotates)
module psu_step
  import psu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] so_cur,
  input  logic [1:0]       mode,
  input  logic             ser_in,
  output logic [WIDTH-1:0] so_next,
  output logic             out_bit
);

  always_comb begin
    so_next = so_cur;
    out_bit = 1'b0;
    case (mode)
      PSU_SHL: begin
        so_next = {so_cur[WIDTH-2:0], ser_in};
        out_bit = so_cur[WIDTH-1];
      end
      PSU_SHR: begin
        so_next = {ser_in, so_cur[WIDTH-1:1]};
        out_bit = so_cur[0];
      end
      PSU_ROL: begin
        so_next = {so_cur[WIDTH-2:0], so_cur[WIDTH-1]};
        out_bit = so_cur[WIDTH-1];
      end
      PSU_ROR: begin
`ifdef PSU_ASR_EN
        // Arithmetic right shift: sign bit is replicated.
        so_next = {so_cur[WIDTH-1], so_cur[WIDTH-1:1]};
`else
        so_next = {so_cur[0], so_cur[WIDTH-1:1]};
`endif
        out_bit = so_cur[0];
      end
      default: begin
        so_next = so_cur;
        out_bit = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/param_shift_unit.sv
// param_shift_unit: parametrised multi-mode shift register with a counted
// shift controller. Parallel-loads a word, then on start performs 'amount'
// (saturated to WIDTH) single-bit steps, one per clock.
// Config macro: PSU_ASR_EN (selects ASR instead of ROR for mode 11, see psu_step).
// Ports:
//   clk       in  1      clock, rising edge
//   rst       in  1      asynchronous reset, active low
//   si        in  WIDTH  parallel load data
//   load      in  1      parallel load / abort strobe
//   start     in  1      begin shift sequence (sampled in IDLE only)
//   mode      in  2      step mode, latched with start
//   amount    in  CNT_W  number of steps, latched with start
//   ser_in    in  1      fill bit for SHL/SHR
//   so        out WIDTH  register contents
//   ser_out   out 1      bit that left on the most recent step
//   busy      out 1      high while in SHIFT
//   done      out 1      one-cycle pulse in DONE
//   state_dbg out 2      current FSM state (psu_state_e encoding)
//
// Handshake: start is a request accepted only when busy=0 and the FSM is idle;
// mode/amount are captured on that edge and ignored afterwards. Completion is
// signalled by a single-cycle done pulse; load at any time aborts without done.
module param_shift_unit
  import psu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = psu_clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] si,
  input  logic             load,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] amount,
  input  logic             ser_in,
  output logic [WIDTH-1:0] so,
  output logic             ser_out,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_dbg
);

  psu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] so_q, so_d;
  logic             ser_out_q, ser_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] step_so;
  logic             step_bit;

  psu_step #(.WIDTH(WIDTH)) u_step (
    .so_cur  (so_q),
    .mode    (mode_q),
    .ser_in  (ser_in),
    .so_next (step_so),
    .out_bit (step_bit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mode_q    <= PSU_SHL;
      so_q      <= '0;
      ser_out_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      so_q      <= so_d;
      ser_out_q <= ser_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    so_d      = so_q;
    ser_out_d = ser_out_q;
    if (load) begin
      // Load wins in every state; in SHIFT/DONE it aborts with no done pulse.
      so_d    = si;
      cnt_d   = '0;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            mode_d  = mode;
            cnt_d   = (amount > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : amount;
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (cnt_q != '0) begin
            so_d      = step_so;
            ser_out_d = step_bit;
            cnt_d     = cnt_q - CNT_W'(1);
          end else begin
            state_d = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    // busy/done are registered decodes of the next state.
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  assign so        = so_q;
  assign ser_out   = ser_out_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_param_shift_unit.sv
// tb_param_shift_unit: directed self-checking bench for param_shift_unit (WIDTH=8).
// Honours PSU_ASR_EN for the mode 11 expectation.
module tb_param_shift_unit;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] si;
  logic             load;
  logic             start;
  logic [1:0]       mode;
  logic [CNT_W-1:0] amount;
  logic             ser_in;
  logic [WIDTH-1:0] so;
  logic             ser_out;
  logic             busy;
  logic             done;
  logic [1:0]       state_dbg;

  int n_checks = 0;
  int n_pass   = 0;

  // Scoreboard: expected final word of each shift sequence.
  logic [WIDTH-1:0] exp_q[$];

  param_shift_unit #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .si        (si),
    .load      (load),
    .start     (start),
    .mode      (mode),
    .amount    (amount),
    .ser_in    (ser_in),
    .so        (so),
    .ser_out   (ser_out),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Driver: parallel load, applied and checked on negedges.
  task automatic do_load(input logic [WIDTH-1:0] val, input string tag);
    @(negedge clk);
    si   = val;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check(tag, {24'd0, so}, {24'd0, val});
  endtask

  // Driver: run one full shift sequence and score it.
  task automatic run_shift(input logic [1:0] m, input logic [CNT_W-1:0] amt,
                           input logic sin, input logic [WIDTH-1:0] exp_so,
                           input logic exp_ser, input int exp_busy, input string tag);
    int busy_cnt;
    int guard;
    logic [WIDTH-1:0] e;
    exp_q.push_back(exp_so);
    @(negedge clk);
    mode   = m;
    amount = amt;
    ser_in = sin;
    start  = 1'b1;
    @(negedge clk);          // edge 0 has sampled start
    start  = 1'b0;
    mode   = ~m;             // changes while busy must be ignored
    amount = 4'd1;
    busy_cnt = 0;
    guard    = 0;
    while (!done && guard < 40) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      guard++;
    end
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_busy_cycles"}, busy_cnt, exp_busy);
    e = exp_q.pop_front();
    check({tag, "_so"}, {24'd0, so}, {24'd0, e});
    check({tag, "_ser_out"}, {31'd0, ser_out}, {31'd0, exp_ser});
    @(negedge clk);
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    check({tag, "_idle"}, {30'd0, state_dbg}, 32'd0);
  endtask

  initial begin
    int seen_done;
    rst = 1'b0; si = '0; load = 1'b0; start = 1'b0;
    mode = 2'b00; amount = '0; ser_in = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_so", {24'd0, so}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_ser_out", {31'd0, ser_out}, 32'd0);
    check("rst_state", {30'd0, state_dbg}, 32'd0);
    rst = 1'b1;

    // SHL 0xA5 by 3: A5->4A(1)->94(0)->28(1); last bit out is 1.
    do_load(8'hA5, "load_a5");
    run_shift(2'b00, 4'd3, 1'b0, 8'h28, 1'b1, 4, "shl3");

    // ROL 0xA5 by 4 -> 0x5A (last wrapped bit 0), then full rotate keeps 0x5A.
    do_load(8'hA5, "load_a5_rol");
    run_shift(2'b10, 4'd4, 1'b0, 8'h5A, 1'b0, 5, "rol4");
    run_shift(2'b10, 4'd8, 1'b0, 8'h5A, 1'b0, 9, "rol8");

    // SHR 0x81 by 2 with ser_in=1: C0(1) -> E0(0).
    do_load(8'h81, "load_81");
    run_shift(2'b01, 4'd2, 1'b1, 8'hE0, 1'b0, 3, "shr2");

    // Mode 11 on 0x84 by 2: ROR 42->21, ASR C2->E1; both shift out 0,0.
    do_load(8'h84, "load_84");
`ifdef PSU_ASR_EN
    run_shift(2'b11, 4'd2, 1'b0, 8'hE1, 1'b0, 3, "asr2");
`else
    run_shift(2'b11, 4'd2, 1'b0, 8'h21, 1'b0, 3, "ror2");
`endif

    // amount=0: done after edge 1, word and ser_out unchanged.
    do_load(8'h3C, "load_3c");
    run_shift(2'b00, 4'd0, 1'b1, 8'h3C, 1'b0, 1, "amt0");

    // amount=13 saturates to 8: SHL with ser_in=0 clears the word.
    do_load(8'hFF, "load_ff");
    run_shift(2'b00, 4'd13, 1'b0, 8'h00, 1'b1, 9, "amt13");

    // Abort by load mid-shift: word reloaded, idle, no done pulse.
    do_load(8'h0F, "load_0f");
    @(negedge clk);
    mode = 2'b00; amount = 4'd8; ser_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    si = 8'h96; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("abort_so", {24'd0, so}, 32'h96);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_state", {30'd0, state_dbg}, 32'd0);
    seen_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    check("abort_no_done", seen_done, 0);

    // Async reset mid-shift: clears immediately, without a clock edge.
    @(negedge clk);
    mode = 2'b10; amount = 4'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_so", {24'd0, so}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_state", {30'd0, state_dbg}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("arst_hold_busy", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
